// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LDR_BURST = 1'b1
  } arb_state_e;

  localparam int unsigned BURST_MAX_DEFAULT    = 8;
  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;
  localparam int unsigned CNT_WIDTH            = 8;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dmem_arb_rdret.sv
// Per-requester read-return register: captures the combinational memory
// read data of a granted read and presents it one cycle later with rvalid.
module dmem_arb_rdret
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_fire,
  input  logic [DATA_WIDTH-1:0] mem_rd,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid
);

  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
  logic                  rvalid_d, rvalid_q;

  // Capture read data only on a granted read; hold it otherwise.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = rd_fire;
    if (rd_fire) begin
      rdata_d = mem_rd;
    end
  end

  // Return register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata = rdata_q;
  // Masked while rst is high so a read granted just before reset never
  // surfaces as a late rvalid.
  assign rvalid = rvalid_q & ~rst;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter (CPU vs. loader) with locked loader
// bursts. Optional starvation guard enabled by DMEM_ARBITER_STARVE_GUARD_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned BURST_MAX     = BURST_MAX_DEFAULT,
  parameter int unsigned STARVE_LIMIT  = STARVE_LIMIT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic                     cpu_addr_mode,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wd,
  output logic                     cpu_gnt,
  output logic                     cpu_stall,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     cpu_rvalid,
  input  logic                     ldr_req,
  input  logic                     ldr_we,
  input  logic                     ldr_lock,
  input  logic                     ldr_addr_mode,
  input  logic [ADDRESS_WIDTH-1:0] ldr_addr,
  input  logic [DATA_WIDTH-1:0]    ldr_wd,
  output logic                     ldr_gnt,
  output logic                     ldr_rvalid,
  output logic [DATA_WIDTH-1:0]    ldr_rdata,
  output logic                     mem_we,
  output logic                     mem_addr_mode,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  input  logic [DATA_WIDTH-1:0]    mem_rd
);

  localparam logic [CNT_WIDTH-1:0] BURST_MAX_C    = CNT_WIDTH'(BURST_MAX);
  localparam logic [CNT_WIDTH-1:0] STARVE_LIMIT_C = CNT_WIDTH'(STARVE_LIMIT);

`ifdef DMEM_ARBITER_STARVE_GUARD_EN
  localparam bit STARVE_GUARD = 1'b1;
`else
  localparam bit STARVE_GUARD = 1'b0;
`endif

  arb_state_e           state_d, state_q;
  logic [CNT_WIDTH-1:0] burst_cnt_d, burst_cnt_q;
  logic [CNT_WIDTH-1:0] wait_cnt_d, wait_cnt_q;

  logic guard_fire;
  logic burst_exit;
  logic arb_idle;

  // Constant-folds to 0 when the guard is compiled out.
  assign guard_fire = STARVE_GUARD & (wait_cnt_q >= STARVE_LIMIT_C);
  assign burst_exit = ~ldr_req | ~ldr_lock | (burst_cnt_q == BURST_MAX_C) | guard_fire;

  // Next-state and grant logic. A burst exit cycle arbitrates exactly like
  // IDLE, so a still-locked loader can immediately reopen a fresh burst.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    cpu_gnt     = 1'b0;
    ldr_gnt     = 1'b0;
    arb_idle    = 1'b0;

    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          arb_idle = 1'b1;
        end
        LDR_BURST: begin
          if (burst_exit) begin
            arb_idle = 1'b1;
          end else begin
            ldr_gnt     = 1'b1;
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end
        default: begin
          arb_idle = 1'b1;
        end
      endcase

      if (arb_idle) begin
        state_d     = IDLE;
        burst_cnt_d = '0;
        if (cpu_req) begin
          cpu_gnt = 1'b1;
        end else if (ldr_req) begin
          ldr_gnt = 1'b1;
          if (ldr_lock) begin
            state_d     = LDR_BURST;
            burst_cnt_d = CNT_WIDTH'(1);
          end
        end
      end
    end
  end

  // Memory port steering and CPU starvation counter.
  always_comb begin
    mem_we        = 1'b0;
    mem_addr_mode = 1'b0;
    mem_addr      = '0;
    mem_wd        = '0;
    if (cpu_gnt) begin
      mem_we        = cpu_we;
      mem_addr_mode = cpu_addr_mode;
      mem_addr      = cpu_addr;
      mem_wd        = cpu_wd;
    end else if (ldr_gnt) begin
      mem_we        = ldr_we;
      mem_addr_mode = ldr_addr_mode;
      mem_addr      = ldr_addr;
      mem_wd        = ldr_wd;
    end

    cpu_stall  = cpu_req & ~cpu_gnt;
    wait_cnt_d = cpu_stall ? sat_inc(wait_cnt_q) : '0;
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  dmem_arb_rdret #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_cpu_rdret (
    .clk    (clk),
    .rst    (rst),
    .rd_fire(cpu_gnt & ~cpu_we),
    .mem_rd (mem_rd),
    .rdata  (cpu_rdata),
    .rvalid (cpu_rvalid)
  );

  dmem_arb_rdret #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ldr_rdret (
    .clk    (clk),
    .rst    (rst),
    .rd_fire(ldr_gnt & ~ldr_we),
    .mem_rd (mem_rd),
    .rdata  (ldr_rdata),
    .rvalid (ldr_rvalid)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter.
module tb_dmem_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam logic [31:0] RD_KEY = 32'h5A5A_0F0F;

`ifdef DMEM_ARBITER_STARVE_GUARD_EN
  localparam int STALL_CYCLES = 4;
`else
  localparam int STALL_CYCLES = 7;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_addr_mode;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wd;
  logic          cpu_gnt, cpu_stall, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          ldr_req, ldr_we, ldr_lock, ldr_addr_mode;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wd;
  logic          ldr_gnt, ldr_rvalid;
  logic [DW-1:0] ldr_rdata;
  logic          mem_we, mem_addr_mode;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  assign mem_rd = mem_addr ^ RD_KEY;

  dmem_arbiter #(
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(AW),
    .BURST_MAX    (8),
    .STARVE_LIMIT (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr_mode(cpu_addr_mode),
    .cpu_addr     (cpu_addr),
    .cpu_wd       (cpu_wd),
    .cpu_gnt      (cpu_gnt),
    .cpu_stall    (cpu_stall),
    .cpu_rdata    (cpu_rdata),
    .cpu_rvalid   (cpu_rvalid),
    .ldr_req      (ldr_req),
    .ldr_we       (ldr_we),
    .ldr_lock     (ldr_lock),
    .ldr_addr_mode(ldr_addr_mode),
    .ldr_addr     (ldr_addr),
    .ldr_wd       (ldr_wd),
    .ldr_gnt      (ldr_gnt),
    .ldr_rvalid   (ldr_rvalid),
    .ldr_rdata    (ldr_rdata),
    .mem_we       (mem_we),
    .mem_addr_mode(mem_addr_mode),
    .mem_addr     (mem_addr),
    .mem_wd       (mem_wd),
    .mem_rd       (mem_rd)
  );

  task automatic drive_idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr_mode = 1'b0; cpu_addr = '0; cpu_wd = '0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_lock = 1'b0; ldr_addr_mode = 1'b0;
    ldr_addr = '0; ldr_wd = '0;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive_idle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    cpu_req = 1'b1; cpu_we = 1'b1; ldr_req = 1'b1; ldr_we = 1'b1;
    @(negedge clk); #1;
    checks++; if (cpu_gnt !== 1'b0) $display("FAIL rst_cpu_gnt got %b want 0", cpu_gnt); else passes++;
    checks++; if (ldr_gnt !== 1'b0) $display("FAIL rst_ldr_gnt got %b want 0", ldr_gnt); else passes++;
    checks++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we got %b want 0", mem_we); else passes++;
    checks++; if (cpu_rvalid !== 1'b0 || ldr_rvalid !== 1'b0)
      $display("FAIL rst_rvalid got %b/%b want 0/0", cpu_rvalid, ldr_rvalid); else passes++;
    checks++; if (cpu_rdata !== '0 || ldr_rdata !== '0)
      $display("FAIL rst_rdata got %h/%h want 0/0", cpu_rdata, ldr_rdata); else passes++;
    checks++; if (cpu_stall !== 1'b1) $display("FAIL rst_cpu_stall got %b want 1", cpu_stall); else passes++;
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
  endtask

  task automatic test_priority();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_lock = 1'b0; ldr_addr = 32'h20;
    #1;
    checks++; if (cpu_gnt !== 1'b1 || ldr_gnt !== 1'b0)
      $display("FAIL prio_gnt got cpu=%b ldr=%b want cpu=1 ldr=0", cpu_gnt, ldr_gnt); else passes++;
    checks++; if (mem_addr !== 32'h10) $display("FAIL prio_mem_addr got %h want 10", mem_addr); else passes++;
    checks++; if (cpu_stall !== 1'b0) $display("FAIL prio_stall got %b want 0", cpu_stall); else passes++;
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    checks++; if (cpu_rvalid !== 1'b1) $display("FAIL prio_cpu_rvalid got %b want 1", cpu_rvalid); else passes++;
    checks++; if (cpu_rdata !== (32'h10 ^ RD_KEY))
      $display("FAIL prio_cpu_rdata got %h want %h", cpu_rdata, 32'h10 ^ RD_KEY); else passes++;
    checks++; if (ldr_gnt !== 1'b1 || mem_addr !== 32'h20)
      $display("FAIL prio_ldr_gnt got gnt=%b addr=%h want gnt=1 addr=20", ldr_gnt, mem_addr); else passes++;
    @(negedge clk);
    ldr_req = 1'b0;
    #1;
    checks++; if (ldr_rvalid !== 1'b1 || ldr_rdata !== (32'h20 ^ RD_KEY))
      $display("FAIL prio_ldr_ret got v=%b d=%h want v=1 d=%h", ldr_rvalid, ldr_rdata, 32'h20 ^ RD_KEY); else passes++;
    checks++; if (cpu_rvalid !== 1'b0) $display("FAIL prio_cpu_rvalid_once got %b want 0", cpu_rvalid); else passes++;
    quiet(2);
  endtask

  task automatic test_burst_max();
    for (int b = 1; b <= 10; b++) begin
      @(negedge clk);
      ldr_req = 1'b1; ldr_lock = 1'b1; ldr_we = 1'b1;
      ldr_addr = 32'h100 + 32'(b * 4); ldr_wd = 32'(b);
      #1;
      checks++; if (ldr_gnt !== 1'b1 || cpu_gnt !== 1'b0)
        $display("FAIL burst_gnt beat %0d got ldr=%b cpu=%b want ldr=1 cpu=0", b, ldr_gnt, cpu_gnt); else passes++;
      checks++; if (mem_we !== 1'b1 || mem_wd !== 32'(b))
        $display("FAIL burst_mem beat %0d got we=%b wd=%h want we=1 wd=%h", b, mem_we, mem_wd, 32'(b)); else passes++;
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++; if (ldr_rvalid !== 1'b0) $display("FAIL burst_no_rvalid got %b want 0", ldr_rvalid); else passes++;
    checks++; if (ldr_gnt !== 1'b0 || mem_we !== 1'b0)
      $display("FAIL burst_release got gnt=%b we=%b want 0/0", ldr_gnt, mem_we); else passes++;
    quiet(2);
  endtask

  task automatic test_starve();
    logic exp_gnt;
    @(negedge clk);
    ldr_req = 1'b1; ldr_lock = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h200;
    #1;
    checks++; if (ldr_gnt !== 1'b1) $display("FAIL starve_first_beat got %b want 1", ldr_gnt); else passes++;
    for (int k = 1; k <= STALL_CYCLES + 1; k++) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wd = 32'hC0FFEE;
      #1;
      exp_gnt = (k == STALL_CYCLES + 1);
      checks++; if (cpu_gnt !== exp_gnt || cpu_stall !== ~exp_gnt || ldr_gnt !== ~exp_gnt)
        $display("FAIL starve_cycle %0d got gnt=%b stall=%b ldr=%b want gnt=%b stall=%b ldr=%b",
                 k, cpu_gnt, cpu_stall, ldr_gnt, exp_gnt, ~exp_gnt, ~exp_gnt); else passes++;
    end
    checks++; if (mem_addr !== 32'h40 || mem_wd !== 32'hC0FFEE)
      $display("FAIL starve_mem got addr=%h wd=%h want 40/c0ffee", mem_addr, mem_wd); else passes++;
    quiet(2);
  endtask

  task automatic test_lock_drop();
    @(negedge clk);
    ldr_req = 1'b1; ldr_lock = 1'b1; ldr_we = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (ldr_gnt !== 1'b1) $display("FAIL lock_beat2 got %b want 1", ldr_gnt); else passes++;
    @(negedge clk);
    ldr_lock = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1;
    #1;
    checks++; if (cpu_gnt !== 1'b1 || ldr_gnt !== 1'b0)
      $display("FAIL lock_drop got cpu=%b ldr=%b want cpu=1 ldr=0", cpu_gnt, ldr_gnt); else passes++;
    quiet(2);
  endtask

  task automatic test_reset_in_burst();
    @(negedge clk);
    ldr_req = 1'b1; ldr_lock = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h80;
    @(negedge clk);
    ldr_addr = 32'h84;
    #1;
    checks++; if (ldr_gnt !== 1'b1 || ldr_rvalid !== 1'b1)
      $display("FAIL rib_beat2 got gnt=%b rvalid=%b want 1/1", ldr_gnt, ldr_rvalid); else passes++;
    @(negedge clk);
    rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1;
    #1;
    checks++; if (ldr_rvalid !== 1'b0) $display("FAIL rib_rvalid_masked got %b want 0", ldr_rvalid); else passes++;
    checks++; if (ldr_gnt !== 1'b0 || cpu_gnt !== 1'b0 || mem_we !== 1'b0)
      $display("FAIL rib_gnt got ldr=%b cpu=%b we=%b want 0/0/0", ldr_gnt, cpu_gnt, mem_we); else passes++;
    @(negedge clk);
    rst = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h90;
    #1;
    checks++; if (ldr_rvalid !== 1'b0 || ldr_rdata !== '0)
      $display("FAIL rib_after_rst got v=%b d=%h want 0/0", ldr_rvalid, ldr_rdata); else passes++;
    checks++; if (cpu_gnt !== 1'b1 || ldr_gnt !== 1'b0)
      $display("FAIL rib_idle_gnt got cpu=%b ldr=%b want 1/0", cpu_gnt, ldr_gnt); else passes++;
    @(negedge clk);
    drive_idle();
    #1;
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== (32'h90 ^ RD_KEY))
      $display("FAIL rib_cpu_ret got v=%b d=%h want 1/%h", cpu_rvalid, cpu_rdata, 32'h90 ^ RD_KEY); else passes++;
    quiet(2);
  endtask

  task automatic test_random();
    logic          exp_cv, exp_lv;
    logic [DW-1:0] exp_cd, exp_ld;
    exp_cv = 1'b0; exp_lv = 1'b0; exp_cd = '0; exp_ld = '0;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      cpu_req = ($urandom_range(0, 9) < 3); cpu_we = $urandom_range(0, 1) == 1;
      cpu_addr = $urandom; cpu_wd = $urandom; cpu_addr_mode = $urandom_range(0, 1) == 1;
      ldr_req = ($urandom_range(0, 9) < 7); ldr_we = $urandom_range(0, 1) == 1;
      ldr_lock = ($urandom_range(0, 9) < 8); ldr_addr = $urandom; ldr_wd = $urandom;
      ldr_addr_mode = $urandom_range(0, 1) == 1;
      #1;
      checks++; if ((cpu_gnt & ldr_gnt) !== 1'b0)
        $display("FAIL rnd_excl cycle %0d got cpu=%b ldr=%b want not both", n, cpu_gnt, ldr_gnt); else passes++;
      checks++; if (cpu_rvalid !== exp_cv || (exp_cv && cpu_rdata !== exp_cd))
        $display("FAIL rnd_cpu_ret cycle %0d got v=%b d=%h want v=%b d=%h", n, cpu_rvalid, cpu_rdata, exp_cv, exp_cd); else passes++;
      checks++; if (ldr_rvalid !== exp_lv || (exp_lv && ldr_rdata !== exp_ld))
        $display("FAIL rnd_ldr_ret cycle %0d got v=%b d=%h want v=%b d=%h", n, ldr_rvalid, ldr_rdata, exp_lv, exp_ld); else passes++;
      exp_cv = cpu_gnt & ~cpu_we; exp_cd = cpu_addr ^ RD_KEY;
      exp_lv = ldr_gnt & ~ldr_we; exp_ld = ldr_addr ^ RD_KEY;
    end
    quiet(2);
  endtask

  initial begin
    test_reset();
    test_priority();
    test_burst_max();
    test_starve();
    test_lock_drop();
    test_reset_in_burst();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
